// File: rtl/mem_pkg.sv
// mem_pkg: shared state enum, bus widths and field positions for the memory stage.
package mem_pkg;
  typedef enum logic {S_IDLE, S_WAIT} mem_state_e;
  localparam int MEM_DATA_W  = 69;
  localparam int WB_DATA_W   = 69;
  localparam int MEM_BACK_W  = 38;
  localparam int WB_CTRL_W   = 5;
  localparam int RW_MSB      = 68;
  localparam int EX_MSB      = 63;
  localparam int EX_LSB      = 32;
  localparam int RD2_MSB     = 31;
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 4;
endpackage

// File: rtl/mem_req_fsm.sv
// mem_req_fsm: data-memory handshake FSM with wait counter, timeout and flush-drop flag.
module mem_req_fsm import mem_pkg::*; #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  input  logic flush,
  output logic stall,
  output logic timeout,
  output logic drop,
  output logic busy
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  mem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic drop_q, drop_d;
  always_comb begin
    busy = state_q == S_WAIT;
    timeout = busy & req & ~ready & (cnt_q == CW'(MAX_WAIT));
    stall = req & ~ready & ~timeout;
    state_d = stall ? S_WAIT : S_IDLE;
    cnt_d = stall ? cnt_q + CW'(1) : '0;
    drop_d = busy & stall & (drop_q | flush);
    drop = drop_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with stalling data-memory interface.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access rejection and o_ADDR_ERR.
module mem_stage import mem_pkg::*; #(
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_FLUSH,
  input  logic                  MEM_CTRL,
  input  logic [WB_CTRL_W-1:0]  WB_CTRL,
  input  logic [MEM_DATA_W-1:0] MEM_DATA,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [31:0]           dm_addr,
  output logic [31:0]           dm_wdata,
  input  logic [31:0]           dm_rdata,
  input  logic                  dm_ready,
  output logic                  MEM_STALL,
  output logic [MEM_BACK_W-1:0] MEM_BACK,
  output logic [WB_CTRL_W-1:0]  o_WB_CTRL,
  output logic [WB_DATA_W-1:0]  o_WB_DATA,
  output logic                  o_BUS_ERR
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  o_ADDR_ERR
`endif
);
  logic active, load, squash, req, aerr, stall, timeout, drop, busy, bubble;
  logic [WB_CTRL_W-1:0] wb_ctrl_d, wb_ctrl_q;
  logic [WB_DATA_W-1:0] wb_data_d, wb_data_q;
  logic bus_err_q;
  always_comb begin
    active = MEM_CTRL | WB_CTRL[WB_MEMTOREG];
    load = WB_CTRL[WB_MEMTOREG] & ~MEM_CTRL;
    squash = MEM_FLUSH & ~busy;
`ifdef MEM_ALIGN_CHECK_EN
    aerr = active & ~squash & (MEM_DATA[EX_LSB+1:EX_LSB] != 2'b00);
`else
    aerr = 1'b0;
`endif
    req = active & ~squash & ~aerr & ~rst;
    bubble = MEM_FLUSH | drop | timeout | aerr;
    wb_ctrl_d = (stall | bubble) ? '0 : WB_CTRL;
    wb_data_d = stall ? wb_data_q : {MEM_DATA[RW_MSB:EX_LSB], load ? dm_rdata : MEM_DATA[RD2_MSB:0]};
  end
  mem_req_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
    .clk(clk), .rst(rst), .req(req), .ready(dm_ready), .flush(MEM_FLUSH),
    .stall(stall), .timeout(timeout), .drop(drop), .busy(busy)
  );
  // Load data is deliberately never forwarded from this stage.
  assign MEM_BACK = {WB_CTRL[WB_REGWRITE] & ~WB_CTRL[WB_MEMTOREG] & ~MEM_FLUSH, MEM_DATA[RW_MSB:EX_LSB]};
  assign dm_req = req;
  assign dm_we = MEM_CTRL;
  assign dm_addr = MEM_DATA[EX_MSB:EX_LSB];
  assign dm_wdata = MEM_DATA[RD2_MSB:0];
  assign MEM_STALL = stall;
  assign o_WB_CTRL = wb_ctrl_q;
  assign o_WB_DATA = wb_data_q;
  assign o_BUS_ERR = bus_err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_ctrl_q <= '0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wb_ctrl_q <= wb_ctrl_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= timeout;
    end
`ifdef MEM_ALIGN_CHECK_EN
  logic addr_err_q;
  assign o_ADDR_ERR = addr_err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) addr_err_q <= 1'b0;
    else addr_err_q <= aerr;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a cycle-level model.
module tb_mem_stage;
  localparam int MAX_WAIT = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic flush = 1'b0, mc = 1'b0, ready = 1'b0;
  logic [4:0] wbc = '0;
  logic [68:0] md = '0;
  logic [31:0] rdata = '0;
  logic dm_req, dm_we, MEM_STALL, o_BUS_ERR;
  logic [31:0] dm_addr, dm_wdata;
  logic [37:0] MEM_BACK;
  logic [4:0] o_WB_CTRL;
  logic [68:0] o_WB_DATA;
`ifdef MEM_ALIGN_CHECK_EN
  logic o_ADDR_ERR;
`endif
  int checks = 0, errs = 0;
  int m_wait = 0;
  logic m_drop = 0, m_err = 0, m_aerr = 0, seen_stall = 0, seen_we = 0;
  logic [4:0] m_ctrl = '0;
  logic [68:0] m_data = '0;

  mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .MEM_FLUSH(flush), .MEM_CTRL(mc), .WB_CTRL(wbc), .MEM_DATA(md),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(rdata), .dm_ready(ready), .MEM_STALL(MEM_STALL), .MEM_BACK(MEM_BACK),
    .o_WB_CTRL(o_WB_CTRL), .o_WB_DATA(o_WB_DATA), .o_BUS_ERR(o_BUS_ERR)
`ifdef MEM_ALIGN_CHECK_EN
    , .o_ADDR_ERR(o_ADDR_ERR)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic m, input logic [4:0] w, input logic [68:0] d,
                       input logic r, input logic [31:0] rd);
    flush = f; mc = m; wbc = w; md = d; ready = r; rdata = rd;
  endtask

  task automatic model_reset();
    m_wait = 0; m_drop = 0; m_err = 0; m_aerr = 0; m_ctrl = '0; m_data = '0;
  endtask

  // One clock: combinational checks mid-cycle, registered checks just after the edge.
  task automatic cycle();
    logic act, req, to, st, ae;
    @(negedge clk);
    act = mc | wbc[4];
    req = act & !(flush && m_wait == 0);
    ae = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    ae = req & (md[33:32] != 2'b00);
    req = req & !ae;
`endif
    to = req & !ready & (m_wait == MAX_WAIT);
    st = req & !ready & !to;
    chk("dm_req", 69'(dm_req), 69'(req));
    chk("stall", 69'(MEM_STALL), 69'(st));
    chk("dm_we", 69'(dm_we), 69'(mc));
    chk("addr_wdata", 69'({dm_addr, dm_wdata}), 69'(md[63:0]));
    chk("mem_back", 69'(MEM_BACK), 69'({wbc[0] & !wbc[4] & !flush, md[68:32]}));
    seen_stall = MEM_STALL;
    seen_we = dm_we;
    if (st) begin
      m_drop = m_drop | (flush & (m_wait > 0));
      m_wait++;
      m_ctrl = '0;
    end else begin
      m_ctrl = (flush | m_drop | to | ae) ? 5'd0 : wbc;
      m_data = {md[68:32], (wbc[4] & !mc) ? rdata : md[31:0]};
      m_wait = 0;
      m_drop = 0;
    end
    m_err = to;
    m_aerr = ae;
    @(posedge clk);
    #1;
    chk("wb_ctrl", 69'(o_WB_CTRL), 69'(m_ctrl));
    chk("wb_data", o_WB_DATA, m_data);
    chk("bus_err", 69'(o_BUS_ERR), 69'(m_err));
`ifdef MEM_ALIGN_CHECK_EN
    chk("addr_err", 69'(o_ADDR_ERR), 69'(m_aerr));
`endif
  endtask

  initial begin
    int n, nwe, k, w;
    logic hold;
    drive(0, 0, 5'h11, {5'd1, 32'h40, 32'h0}, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_req", 69'(dm_req), 69'd0);
    chk("rst_ctrl", 69'(o_WB_CTRL), 69'd0);
    chk("rst_data", o_WB_DATA, 69'd0);
    chk("rst_err", 69'(o_BUS_ERR), 69'd0);
    model_reset();
    drive(0, 0, 5'h01, {5'd3, 32'h1234, 32'h0}, 1, 0);
    #2 rst = 1'b0;
    cycle();
    chk("alu_back", 69'(MEM_BACK), 69'({1'b1, 5'd3, 32'h1234}));
    chk("alu_ctrl", 69'(o_WB_CTRL), 69'h01);
    chk("alu_data", 69'(o_WB_DATA[68:32]), 69'({5'd3, 32'h1234}));
    drive(0, 0, 5'h11, {5'd4, 32'h100, 32'h0}, 1, 32'hDEADBEEF);
    cycle();
    chk("ld0_stall", 69'(seen_stall), 69'd0);
    chk("ld0_data", 69'(o_WB_DATA[31:0]), 69'h0DEADBEEF);
    chk("ld0_ctrl", 69'(o_WB_CTRL), 69'h11);
    n = 0; nwe = 0;
    drive(0, 1, 5'h02, {5'd0, 32'h200, 32'hCAFE0001}, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n += int'(seen_stall); nwe += int'(seen_we);
      chk("st_bubble", 69'(o_WB_CTRL), 69'd0);
    end
    ready = 1'b1;
    cycle();
    nwe += int'(seen_we);
    chk("st_stalls", 69'(n), 69'd3);
    chk("st_we", 69'(nwe), 69'd4);
    chk("st_ctrl", 69'(o_WB_CTRL), 69'h02);
    chk("st_data", 69'(o_WB_DATA[31:0]), 69'hCAFE0001);
    n = 0;
    drive(0, 0, 5'h11, {5'd5, 32'h300, 32'h0}, 0, 32'h55);
    for (int i = 0; i < 30 && !o_BUS_ERR; i++) begin
      cycle();
      n += int'(seen_stall);
    end
    chk("to_err", 69'(o_BUS_ERR), 69'd1);
    chk("to_stalls", 69'(n), 69'd15);
    chk("to_bubble", 69'(o_WB_CTRL), 69'd0);
    drive(0, 0, 5'h01, {5'd1, 32'h4, 32'h0}, 1, 0);
    cycle();
    drive(0, 0, 5'h11, {5'd6, 32'h400, 32'h0}, 0, 32'hA5A5A5A5);
    repeat (15) cycle();
    ready = 1'b1;
    cycle();
    chk("edge_err", 69'(o_BUS_ERR), 69'd0);
    chk("edge_ctrl", 69'(o_WB_CTRL), 69'h11);
    chk("edge_data", 69'(o_WB_DATA[31:0]), 69'hA5A5A5A5);
    drive(0, 0, 5'h11, {5'd7, 32'h500, 32'h0}, 0, 32'h0BADF00D);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    cycle();
    ready = 1'b1;
    cycle();
    chk("fl_ctrl", 69'(o_WB_CTRL), 69'd0);
    chk("fl_data", 69'(o_WB_DATA[31:0]), 69'h0BADF00D);
`ifdef MEM_ALIGN_CHECK_EN
    drive(0, 0, 5'h11, {5'd2, 32'h102, 32'h0}, 0, 0);
    cycle();
    chk("al_err", 69'(o_ADDR_ERR), 69'd1);
    chk("al_ctrl", 69'(o_WB_CTRL), 69'd0);
    chk("al_stall", 69'(seen_stall), 69'd0);
`endif
    drive(0, 0, 5'h11, {5'd8, 32'h600, 32'h0}, 0, 0);
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("rw_req", 69'(dm_req), 69'd0);
    chk("rw_stall", 69'(MEM_STALL), 69'd0);
    chk("rw_ctrl", 69'(o_WB_CTRL), 69'd0);
    chk("rw_data", o_WB_DATA, 69'd0);
    model_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 5'h00, '0, 1, 0);
    rst = 1'b0;
    hold = 1'b0; k = 0; w = 0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        int kind;
        kind = $urandom_range(0, 3);
        mc = (kind >= 2);
        wbc = 5'($urandom_range(0, 15)) | ((kind == 1 || kind == 3) ? 5'h10 : 5'h00);
        md = {5'($urandom), 32'($urandom), 32'($urandom)};
        w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
        k = 0;
      end
      ready = (k >= w);
      flush = ($urandom_range(0, 7) == 0);
      rdata = 32'($urandom);
      cycle();
      hold = seen_stall;
      k++;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
